// File: rtl/intt_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module   : intt_butterfly_pipe
// Purpose  : Fully pipelined Gentleman-Sande butterfly mod Q (Dilithium INTT),
//            4-cycle latency. Optional write counter under INTT_BF_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module intt_butterfly_pipe #(
    parameter int Q  = 8380417,
    parameter int DW = 23,
    parameter int AW = 8,
    parameter int ZW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [AW-1:0] addr_b_i,
    input  logic [ZW-1:0] zeta_idx_i,
    output logic [AW-1:0] rd_addr_a_o,
    output logic [AW-1:0] rd_addr_b_o,
    input  logic [DW-1:0] rd_data_a_i,
    input  logic [DW-1:0] rd_data_b_i,
    output logic [ZW-1:0] zeta_addr_o,
    input  logic [DW-1:0] zeta_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_a_o,
    output logic [AW-1:0] wr_addr_b_o,
    output logic [DW-1:0] wr_data_a_o,
    output logic [DW-1:0] wr_data_b_o,
    output logic          busy_o,
    output logic          hazard_o
`ifdef INTT_BF_COUNT_EN
    ,
    output logic [10:0]   bf_count_o,
    output logic          done_o
`endif
);

    // 2^DW mod Q == 2^c_K - 1, which lets the product be folded with shifts.
    localparam int c_K   = 13;
    localparam int c_F1W = DW + c_K + 1;
    localparam int c_F2W = 2 * c_K + 2;
    localparam int c_F3W = DW + 1;
    localparam logic [DW:0]   c_Q_X = (DW+1)'(Q);
    localparam logic [DW-1:0] c_Q   = DW'(Q);

    logic          r_v1, r_v2, r_v3, r_wr_en;
    logic [AW-1:0] r_a1, r_b1, r_a2, r_b2, r_a3, r_b3, r_wr_a, r_wr_b;
    logic [DW-1:0] r_s2, r_d2, r_z2, r_s3, r_wr_da, r_wr_db;
    logic [2*DW-1:0] r_p3;
    logic          r_hazard;

    logic [DW:0]     w_sum, w_sum_red, w_diff;
    logic [DW-1:0]   w_s, w_d, w_r;
    logic [c_F1W-1:0] w_f1;
    logic [c_F2W-1:0] w_f2;
    logic [c_F3W-1:0] w_f3, w_r_full;
    logic            w_hit;
    logic [1:0]      w_unused;

    assign rd_addr_a_o = addr_a_i;
    assign rd_addr_b_o = addr_b_i;
    assign zeta_addr_o = zeta_idx_i;

    // Modular add/sub straight off the RAM read bus.
    assign w_sum     = {1'b0, rd_data_a_i} + {1'b0, rd_data_b_i};
    assign w_sum_red = (w_sum >= c_Q_X) ? (w_sum - c_Q_X) : w_sum;
    assign w_s       = w_sum_red[DW-1:0];
    assign w_diff    = {1'b0, rd_data_a_i} - {1'b0, rd_data_b_i};
    assign w_d       = w_diff[DW] ? (w_diff[DW-1:0] + c_Q) : w_diff[DW-1:0];

    // Three folds bring any 46-bit product below 2Q; one subtract finishes it.
    assign w_f1 = {1'b0, r_p3[2*DW-1:DW], {c_K{1'b0}}}
                - c_F1W'(r_p3[2*DW-1:DW]) + c_F1W'(r_p3[DW-1:0]);
    assign w_f2 = {w_f1[c_F1W-1:DW], {c_K{1'b0}}}
                - c_F2W'(w_f1[c_F1W-1:DW]) + c_F2W'(w_f1[DW-1:0]);
    assign w_f3 = c_F3W'({w_f2[c_F2W-1:DW], {c_K{1'b0}}})
                - c_F3W'(w_f2[c_F2W-1:DW]) + c_F3W'(w_f2[DW-1:0]);
    assign w_r_full = (w_f3 >= c_Q_X) ? (w_f3 - c_Q_X) : w_f3;
    assign w_r      = w_r_full[DW-1:0];

    assign w_unused = {w_sum_red[DW], w_r_full[DW]};

    function automatic logic addr_hit(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                                      input logic [AW-1:0] wa, input logic [AW-1:0] wb);
        return (ra == wa) || (ra == wb) || (rb == wa) || (rb == wb);
    endfunction

    assign w_hit = valid_i && (
                   (r_v1    && addr_hit(addr_a_i, addr_b_i, r_a1,   r_b1))   ||
                   (r_v2    && addr_hit(addr_a_i, addr_b_i, r_a2,   r_b2))   ||
                   (r_v3    && addr_hit(addr_a_i, addr_b_i, r_a3,   r_b3))   ||
                   (r_wr_en && addr_hit(addr_a_i, addr_b_i, r_wr_a, r_wr_b)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_wr_en  <= 1'b0;
            r_a1     <= '0;
            r_b1     <= '0;
            r_a2     <= '0;
            r_b2     <= '0;
            r_a3     <= '0;
            r_b3     <= '0;
            r_s2     <= '0;
            r_d2     <= '0;
            r_z2     <= '0;
            r_s3     <= '0;
            r_p3     <= '0;
            r_wr_a   <= '0;
            r_wr_b   <= '0;
            r_wr_da  <= '0;
            r_wr_db  <= '0;
            r_hazard <= 1'b0;
        end else begin
            r_v1     <= valid_i;
            r_a1     <= addr_a_i;
            r_b1     <= addr_b_i;
            r_v2     <= r_v1;
            r_a2     <= r_a1;
            r_b2     <= r_b1;
            r_s2     <= w_s;
            r_d2     <= w_d;
            r_z2     <= zeta_i;
            r_v3     <= r_v2;
            r_a3     <= r_a2;
            r_b3     <= r_b2;
            r_s3     <= r_s2;
            r_p3     <= (2*DW)'(r_d2) * (2*DW)'(r_z2);
            r_wr_en  <= r_v3;
            // Outputs hold their last values across bubbles.
            if (r_v3) begin
                r_wr_a  <= r_a3;
                r_wr_b  <= r_b3;
                r_wr_da <= r_s3;
                r_wr_db <= w_r;
            end
            r_hazard <= r_hazard | w_hit;
        end
    end

    assign wr_en_o     = r_wr_en;
    assign wr_addr_a_o = r_wr_a;
    assign wr_addr_b_o = r_wr_b;
    assign wr_data_a_o = r_wr_da;
    assign wr_data_b_o = r_wr_db;
    assign busy_o      = r_v1 | r_v2 | r_v3 | r_wr_en;
    assign hazard_o    = r_hazard;

`ifdef INTT_BF_COUNT_EN
    localparam logic [10:0] c_LAST = 11'd1023;
    logic [10:0] r_bf_count;

    // 8 layers x 128 butterflies; wraps to zero on the last write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bf_count <= '0;
        end else if (r_wr_en) begin
            r_bf_count <= (r_bf_count == c_LAST) ? 11'd0 : r_bf_count + 11'd1;
        end
    end

    assign bf_count_o = r_bf_count;
    assign done_o     = r_wr_en & (r_bf_count == c_LAST);
`endif

endmodule
`default_nettype wire

// File: tb/tb_intt_butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_intt_butterfly_pipe
// Purpose  : Self-checking bench for intt_butterfly_pipe against a queue-based
//            arithmetic reference model (INTT_BF_COUNT_EN adds counter checks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_intt_butterfly_pipe;

    localparam longint c_Q = 8380417;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [7:0]  addr_a_i, addr_b_i, zeta_idx_i;
    logic [7:0]  rd_addr_a_o, rd_addr_b_o, zeta_addr_o;
    logic [22:0] rd_data_a_i, rd_data_b_i, zeta_i;
    logic        wr_en_o;
    logic [7:0]  wr_addr_a_o, wr_addr_b_o;
    logic [22:0] wr_data_a_o, wr_data_b_o;
    logic        busy_o, hazard_o;
`ifdef INTT_BF_COUNT_EN
    logic [10:0] bf_count_o;
    logic        done_o;
`endif

    intt_butterfly_pipe dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .addr_a_i(addr_a_i), .addr_b_i(addr_b_i), .zeta_idx_i(zeta_idx_i),
        .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
        .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
        .zeta_addr_o(zeta_addr_o), .zeta_i(zeta_i),
        .wr_en_o(wr_en_o), .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o),
        .wr_data_a_o(wr_data_a_o), .wr_data_b_o(wr_data_b_o),
        .busy_o(busy_o), .hazard_o(hazard_o)
`ifdef INTT_BF_COUNT_EN
        , .bf_count_o(bf_count_o), .done_o(done_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Coefficient RAM and zeta ROM with 1-cycle read latency.
    logic [22:0] coef [256];
    logic [22:0] zrom [256];
    always @(posedge clk_i) begin
        rd_data_a_i <= coef[rd_addr_a_o];
        rd_data_b_i <= coef[rd_addr_b_o];
        zeta_i      <= zrom[zeta_addr_o];
    end

    typedef struct {
        int          due;
        logic [7:0]  wa, wb;
        logic [22:0] da, db;
    } op_t;

    op_t         q[$];
    int          cycle, n_cmp, n_fail, n_done, wcount;
    logic        exp_wen, exp_busy, exp_haz;
    logic [7:0]  exp_wa, exp_wb;
    logic [22:0] exp_da, exp_db;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, got, exp);
        end
    endtask

    function automatic bit overlap(input logic [7:0] a0, b0, a1, b1);
        return (a0 == a1) || (a0 == b1) || (b0 == a1) || (b0 == b1);
    endfunction

    task automatic model_clear();
        q.delete();
        exp_wen = 0; exp_busy = 0; exp_haz = 0;
        exp_wa = 0; exp_wb = 0; exp_da = 0; exp_db = 0;
        wcount = 0;
    endtask

    task automatic check_outputs();
        chk("wr_en",     64'(wr_en_o),     64'(exp_wen));
        chk("wr_addr_a", 64'(wr_addr_a_o), 64'(exp_wa));
        chk("wr_addr_b", 64'(wr_addr_b_o), 64'(exp_wb));
        chk("wr_data_a", 64'(wr_data_a_o), 64'(exp_da));
        chk("wr_data_b", 64'(wr_data_b_o), 64'(exp_db));
        chk("busy",      64'(busy_o),      64'(exp_busy));
        chk("hazard",    64'(hazard_o),    64'(exp_haz));
`ifdef INTT_BF_COUNT_EN
        chk("bf_count",  64'(bf_count_o),  64'(wcount));
        chk("done",      64'(done_o),      64'(exp_wen && wcount == 1023));
`endif
    endtask

    task automatic advance(input bit haz_now);
        op_t op;
        if (q.size() > 0 && q[0].due == cycle) begin
            op = q.pop_front();
            exp_wen = 1; exp_wa = op.wa; exp_wb = op.wb; exp_da = op.da; exp_db = op.db;
        end else begin
            exp_wen = 0;
        end
        exp_busy = exp_wen || (q.size() != 0);
        exp_haz  = exp_haz | haz_now;
        check_outputs();
`ifdef INTT_BF_COUNT_EN
        if (done_o === 1'b1) n_done++;
`endif
        if (exp_wen) wcount = (wcount + 1) % 1024;
    endtask

    // One clock cycle: drive inputs, record the op in the model, check outputs.
    task automatic cyc(input bit v, input logic [7:0] aa, input logic [7:0] ab, input logic [7:0] zi);
        bit     haz_now;
        op_t    op;
        longint a, b, z, d;
        valid_i = v; addr_a_i = aa; addr_b_i = ab; zeta_idx_i = zi;
        #1;
        chk("rd_addr_a", 64'(rd_addr_a_o), 64'(aa));
        chk("rd_addr_b", 64'(rd_addr_b_o), 64'(ab));
        chk("zeta_addr", 64'(zeta_addr_o), 64'(zi));
        haz_now = 0;
        if (v) begin
            foreach (q[i]) if (overlap(q[i].wa, q[i].wb, aa, ab)) haz_now = 1;
            if (exp_wen && overlap(exp_wa, exp_wb, aa, ab)) haz_now = 1;
            a = longint'(coef[aa]); b = longint'(coef[ab]); z = longint'(zrom[zi]);
            d = (a - b + c_Q) % c_Q;
            op.due = cycle + 4; op.wa = aa; op.wb = ab;
            op.da = 23'((a + b) % c_Q);
            op.db = 23'((d * z) % c_Q);
            q.push_back(op);
        end
        @(posedge clk_i); #1;
        cycle++;
        advance(haz_now);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        rst_i = 1; valid_i = 0;
        #1;
        model_clear();
        check_outputs();
        @(posedge clk_i); #1;
        cycle++;
        check_outputs();
        rst_i = 0;
    endtask

    task automatic run_one(input logic [7:0] aa, input logic [7:0] ab, input logic [7:0] zi,
                           input logic [22:0] ea, input logic [22:0] eb);
        cyc(1'b1, aa, ab, zi);
        idle(3);
        chk("bound_A", 64'(wr_data_a_o), 64'(ea));
        chk("bound_B", 64'(wr_data_b_o), 64'(eb));
        idle(1);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; n_done = 0; cycle = 0;
        rst_i = 1; valid_i = 0; addr_a_i = 0; addr_b_i = 0; zeta_idx_i = 0;
        for (int i = 0; i < 256; i++) begin coef[i] = 0; zrom[i] = 0; end
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs();
        rst_i = 0;

        // Basic op: a=5, b=3, zeta=2 at addresses 0x00/0x01.
        coef[0] = 23'd5; coef[1] = 23'd3; zrom[7] = 23'd2;
        cyc(1'b1, 8'h00, 8'h01, 8'h07);
        idle(3);
        chk("basic_wr_en", 64'(wr_en_o), 64'd1);
        chk("basic_A", 64'(wr_data_a_o), 64'd8);
        chk("basic_B", 64'(wr_data_b_o), 64'd4);
        chk("basic_addr_b", 64'(wr_addr_b_o), 64'h01);
        idle(1);
        chk("basic_busy_fall", 64'(busy_o), 64'd0);

        // Modular boundary cases.
        coef[8'h20] = 23'd8380416; coef[8'h21] = 23'd8380416; zrom[3] = 23'd5;
        coef[8'h22] = 23'd0;       coef[8'h23] = 23'd1;       zrom[4] = 23'd1;
        coef[8'h24] = 23'd8380416; coef[8'h25] = 23'd0;       zrom[5] = 23'd8380416;
        run_one(8'h20, 8'h21, 8'h03, 23'd8380415, 23'd0);
        run_one(8'h22, 8'h23, 8'h04, 23'd1,       23'd8380416);
        run_one(8'h24, 8'h25, 8'h05, 23'd8380416, 23'd1);

        // Throughput: 128 back-to-back ops on disjoint addresses.
        for (int i = 0; i < 256; i++) begin
            coef[i] = 23'($urandom_range(0, 32'(c_Q - 1)));
            zrom[i] = 23'($urandom_range(0, 32'(c_Q - 1)));
        end
        for (int i = 0; i < 128; i++)
            cyc(1'b1, 8'(2 * i), 8'(2 * i + 1), 8'($urandom_range(0, 255)));
        idle(5);
        chk("thr_hazard", 64'(hazard_o), 64'd0);

        // Bubbles: ops at relative cycles 0, 2, 3.
        cyc(1'b1, 8'h40, 8'h41, 8'h11);
        idle(1);
        cyc(1'b1, 8'h42, 8'h43, 8'h12);
        cyc(1'b1, 8'h44, 8'h45, 8'h13);
        idle(5);
        chk("bubble_hazard", 64'(hazard_o), 64'd0);

        // Read-after-write hazard on 0x10.
        cyc(1'b1, 8'h10, 8'h11, 8'h21);
        cyc(1'b1, 8'h10, 8'h12, 8'h22);
        idle(8);
        chk("hazard_sticky", 64'(hazard_o), 64'd1);

        // Reset with three ops in flight, then a fresh op two cycles after release.
        cyc(1'b1, 8'h50, 8'h51, 8'h31);
        cyc(1'b1, 8'h52, 8'h53, 8'h32);
        cyc(1'b1, 8'h54, 8'h55, 8'h33);
        do_reset();
        idle(2);
        cyc(1'b1, 8'h60, 8'h61, 8'h34);
        idle(5);

`ifdef INTT_BF_COUNT_EN
        do_reset();
        n_done = 0;
        for (int i = 0; i < 1024; i++)
            cyc(1'b1, 8'((i % 128) * 2), 8'((i % 128) * 2 + 1), 8'(i));
        idle(5);
        chk("done_pulses", 64'(n_done), 64'd1);
        chk("bf_count_end", 64'(bf_count_o), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intt_butterfly_pipe.md
Name: intt_butterfly_pipe

Overview:
- Datapath stage directly downstream of the INTT address generator.
- Each cycle its write-enable is high, the generator supplies an A/B coefficient address pair and a twiddle index. This block reads the two coefficients from dual-port coefficient RAM and the twiddle from the zeta ROM.
- It performs one Gentleman-Sande butterfly modulo q = 8380417 (Dilithium) and writes both results back in place.
- Fully pipelined: one butterfly per cycle, fixed latency.

Parameters:
- Q, 8380417, modulus.
- DW, 23, coefficient width.
- AW, 8, coefficient address width (N = 256).
- ZW, 8, twiddle index width.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  butterfly request (generator write-enable)
- addr_a_i  in  AW  A coefficient address
- addr_b_i  in  AW  B coefficient address
- zeta_idx_i  in  ZW  twiddle index
- rd_addr_a_o  out  AW  RAM port A read address
- rd_addr_b_o  out  AW  RAM port B read address
- rd_data_a_i  in  DW  RAM port A read data, 1-cycle latency
- rd_data_b_i  in  DW  RAM port B read data, 1-cycle latency
- zeta_addr_o  out  ZW  zeta ROM address
- zeta_i  in  DW  zeta ROM data, 1-cycle latency
- wr_en_o  out  1  write strobe for both ports
- wr_addr_a_o  out  AW  write address A
- wr_addr_b_o  out  AW  write address B
- wr_data_a_o  out  DW  result A
- wr_data_b_o  out  DW  result B
- busy_o  out  1  any stage holds a valid op
- hazard_o  out  1  sticky read-after-write hazard flag

Behaviour:
- Read addresses are combinational pass-throughs:
  - rd_addr_a_o = addr_a_i, rd_addr_b_o = addr_b_i, zeta_addr_o = zeta_idx_i.
  - Reads are issued in cycle 0.
- Pipeline: a valid bit and the address pair travel with each op through stages S1..S4.
  - S1 (cycle 1): register rd_data_a/b and zeta. Inputs are guaranteed < Q.
  - S2: compute
    - s = a + b; if s >= Q then s -= Q.
    - d = a - b; if negative then d += Q.
    - Both results are DW bits, in [0, Q).
  - S3: 46-bit product p = d * zeta (registered).
  - S4: r = p mod Q, fully reduced to [0, Q). The reduction method is free (2^23 ≡ 2^13 - 1 folding or Barrett), but it must complete within this stage's register boundary.
  - Outputs (registered from S4):
    - wr_en_o = 1
    - wr_data_a_o = s
    - wr_data_b_o = r
    - wr_addr_a_o/b_o = original addresses
- Latency: valid_i at edge n gives wr_en_o high during cycle n + 4. Exactly 4 cycles, independent of data.
- Throughput: 1 op per cycle. No backpressure, no stall input. Back-to-back valid_i is always accepted.
- Bubbles: valid_i = 0 inserts a bubble. wr_en_o = 0 in the matching output cycle, and the data/address outputs hold their previous values.
- busy_o = OR of all stage valid bits, including the output register.
- Hazard detection:
  - When valid_i = 1 and addr_a_i or addr_b_i equals the write address of any valid in-flight op (S1..S4, including the output register), set hazard_o.
  - hazard_o stays set until reset.
  - The op still proceeds and reads stale data; no forwarding.
- Reset (any time, including mid-stream):
  - All valid bits, hazard_o, wr_en_o and busy_o = 0.
  - wr_addr_a_o/b_o and wr_data_a_o/b_o = 0.
  - Ops in flight are discarded with no write.
  - First accepted op after release appears 4 cycles later.
- Word widths:
  - Addresses wrap naturally at AW bits; no range check.
  - Inputs >= Q are out of contract; output behaviour is undefined but must not hang the pipeline.

Optional Feature:
- Macro INTT_BF_COUNT_EN.
- When defined, adds two outputs:
  - bf_count_o (11 bits): counts completed writes (wr_en_o cycles).
  - done_o: single-cycle pulse in the cycle the 1024th write (8 layers x 128 butterflies) occurs. The counter then returns to 0.
  - The counter clears on rst_i.
- When not defined: no ports, no counter logic; all other behaviour identical.

Test Plan:
- Basic: reset, then one op with a=5, b=3, zeta=2, addresses 0x00/0x01 -> exactly 4 cycles later wr_en_o = 1, wr_data_a_o = 8, wr_data_b_o = 4, addresses 0x00/0x01. busy_o falls the following cycle.
- Modular bounds:
  - a = b = 8380416, zeta = 5 -> A = 8380415, B = 0.
  - a = 0, b = 1, zeta = 1 -> A = 1, B = 8380416.
  - a = 8380416, b = 0, zeta = 8380416 -> B = 1.
- Throughput: 128 consecutive valid cycles with random in-range data vs a reference model -> 128 consecutive wr_en_o cycles, order preserved, all results match, hazard_o = 0 (disjoint addresses).
- Bubbles and hazard: ops at cycles 0, 2, 3 -> wr_en_o pattern 1,0,1,1 starting at cycle 4. Then issue addr_a = 0x10 one cycle after an op writing 0x10 -> hazard_o = 1 and stays 1.
- Reset mid-stream: assert rst_i with 3 ops in flight -> no wr_en_o after reset, all outputs 0, hazard_o cleared. A new op 2 cycles after release writes correctly.
- INTT_BF_COUNT_EN: 1024 valid ops -> done_o pulses exactly once, coincident with the 1024th wr_en_o, and bf_count_o returns to 0.
